// File: rtl/configure.sv
// Shared SoC configuration: address map of the memory-mapped devices and the
// request bundle used between the core, the arbiter and the peripherals.
package configure;

  // Device windows, each covering base <= addr < top.
  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_TOP    = 32'h0001_0000;
  localparam logic [31:0] UART_BASE  = 32'h0100_0000;
  localparam logic [31:0] UART_TOP   = 32'h0100_1000;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_TOP  = 32'h0200_C000;
  localparam logic [31:0] AVL_BASE   = 32'h8000_0000;
  localparam logic [31:0] AVL_TOP    = 32'h9000_0000;

  // One memory request as issued by a requester.
  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  // Unsigned half-open window test.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] top);
    return (addr >= base) && (addr < top);
  endfunction

endpackage

// File: rtl/mem_decoder.sv
// Address decoder: reports whether an address hits any device window.
module mem_decoder
  import configure::*;
(
  input  logic [31:0] addr,
  output logic        mapped
);

  // An address is mapped when it falls in at least one device window.
  always_comb begin
    mapped = in_range(addr, ROM_BASE, ROM_TOP)
           | in_range(addr, UART_BASE, UART_TOP)
           | in_range(addr, CLINT_BASE, CLINT_TOP)
           | in_range(addr, AVL_BASE, AVL_TOP);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single memory bus.
// One transaction at a time; fair round-robin when both ports request;
// unmapped addresses are answered locally with an error response.
module mem_arbiter
  import configure::*;
(
  input  logic        clock,
  input  logic        reset,

  input  logic        imem_valid,
  input  logic        imem_instr,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstrb,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic        imem_error,

  input  logic        dmem_valid,
  input  logic        dmem_instr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t   state_r;
  state_t   state_nxt;
  mem_req_t req_r;      // request captured at grant time
  logic     last_d_r;   // 1: dmem was served most recently
  logic     owner_d_r;  // 1: the current transaction belongs to dmem
  logic     grant_i;
  logic     grant_d;
  logic     mapped;

  // Decode the captured address; it is stable for the whole transaction.
  mem_decoder u_decoder (
    .addr   (req_r.addr),
    .mapped (mapped)
  );

  // Grant only from IDLE; on a tie favour the port that was not served last.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_r == IDLE) begin
      if (imem_valid && dmem_valid) begin
        grant_d = ~last_d_r;
        grant_i = last_d_r;
      end else begin
        grant_d = dmem_valid;
        grant_i = imem_valid;
      end
    end else begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

  // Next-state logic. An unmapped grant is diverted to ERR before any bus
  // activity; completion always passes through IDLE, so no back-to-back grant.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d) begin
          state_nxt = BUSY_D;
        end else if (grant_i) begin
          state_nxt = BUSY_I;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (!mapped) begin
          state_nxt = ERR;
        end else if (mem_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = state_r;
        end
      end
      ERR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Capture the granted request and remember who was served.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_r     <= '0;
      last_d_r  <= 1'b0;
      owner_d_r <= 1'b0;
    end else if (grant_d) begin
      req_r     <= '{valid: 1'b1, instr: dmem_instr, addr: dmem_addr,
                     wdata: dmem_wdata, wstrb: dmem_wstrb};
      last_d_r  <= 1'b1;
      owner_d_r <= 1'b1;
    end else if (grant_i) begin
      req_r     <= '{valid: 1'b1, instr: imem_instr, addr: imem_addr,
                     wdata: imem_wdata, wstrb: imem_wstrb};
      last_d_r  <= 1'b0;
      owner_d_r <= 1'b0;
    end else begin
      req_r     <= req_r;
      last_d_r  <= last_d_r;
      owner_d_r <= owner_d_r;
    end
  end

  // Output decode. Everything is forced low while reset is asserted so an
  // abandoned transaction never produces a ready pulse.
  always_comb begin
    mem_valid  = 1'b0;
    mem_instr  = 1'b0;
    mem_addr   = 32'h0000_0000;
    mem_wdata  = 32'h0000_0000;
    mem_wstrb  = 4'h0;
    imem_ready = 1'b0;
    imem_error = 1'b0;
    imem_rdata = 32'h0000_0000;
    dmem_ready = 1'b0;
    dmem_error = 1'b0;
    dmem_rdata = 32'h0000_0000;
    if (!reset) begin
      case (state_r)
        BUSY_I, BUSY_D: begin
          if (mapped) begin
            mem_valid = req_r.valid;
            mem_instr = req_r.instr;
            mem_addr  = req_r.addr;
            mem_wdata = req_r.wdata;
            mem_wstrb = req_r.wstrb;
            if (mem_ready && state_r == BUSY_D) begin
              dmem_ready = 1'b1;
              dmem_rdata = mem_rdata;
            end else if (mem_ready) begin
              imem_ready = 1'b1;
              imem_rdata = mem_rdata;
            end else begin
              dmem_ready = 1'b0;
              imem_ready = 1'b0;
            end
          end else begin
            mem_valid = 1'b0;
          end
        end
        ERR: begin
          if (owner_d_r) begin
            dmem_ready = 1'b1;
            dmem_error = 1'b1;
          end else begin
            imem_ready = 1'b1;
            imem_error = 1'b1;
          end
        end
        default: begin
          mem_valid = 1'b0;
        end
      endcase
    end else begin
      mem_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// phase, all checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_valid = 1'b0, imem_instr = 1'b0;
  logic [31:0] imem_addr = '0, imem_wdata = '0;
  logic [3:0]  imem_wstrb = '0;
  logic [31:0] imem_rdata;
  logic        imem_ready, imem_error;
  logic        dmem_valid = 1'b0, dmem_instr = 1'b0;
  logic [31:0] dmem_addr = '0, dmem_wdata = '0;
  logic [3:0]  dmem_wstrb = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_ready, dmem_error;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .dmem_error(dmem_error),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Requesters: index 0 = imem, 1 = dmem.
  logic        r_v [2] = '{1'b0, 1'b0};
  logic        r_done [2] = '{1'b0, 1'b0};
  logic        r_instr [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_wstrb [2];

  // Bench controls.
  int gen_pct = 0;
  int fixed_lat = -1;
  bit noise_en = 1'b0;
  bit force_ready = 1'b0;
  bit rst_drv = 1'b1;

  // Reference model: the one transaction in flight, if any.
  bit          m_active = 1'b0;
  int          m_port = 0;
  int          m_last = 0;   // port served most recently (reset: imem)
  int          m_age = 0;    // cycles since the grant edge
  int          m_lat = 0;    // slave wait cycles after mem_valid rises
  bit          m_mapped = 1'b0;
  logic        m_instr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  // Observations taken from the DUT outputs.
  int          obs_q[$];
  int          err_cnt = 0;
  int          mv_cnt = 0;
  logic [31:0] seen_addr = '0, seen_wdata = '0;
  logic [3:0]  seen_wstrb = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The address map as stated: rom, uart, clint, avl windows.
  function automatic bit is_mapped(input logic [31:0] a);
    return (a < 32'h0001_0000)
        || (a >= 32'h0100_0000 && a < 32'h0100_1000)
        || (a >= 32'h0200_0000 && a < 32'h0200_C000)
        || (a >= 32'h8000_0000 && a < 32'h9000_0000);
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] bases [4];
    logic [31:0] tops [4];
    logic [31:0] a;
    int k;
    bases = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h8000_0000};
    tops  = '{32'h0001_0000, 32'h0100_1000, 32'h0200_C000, 32'h9000_0000};
    k = int'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0, 1, 2: a = bases[k] + ($urandom() % (tops[k] - bases[k]));
      3:       a = tops[k];
      4:       a = tops[k] - 32'd1;
      default: a = $urandom();
    endcase
    return a;
  endfunction

  task automatic new_req(input int p);
    r_v[p]     = 1'b1;
    r_instr[p] = (p == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    r_addr[p]  = pick_addr();
    r_wdata[p] = $urandom();
    r_wstrb[p] = 4'($urandom_range(0, 15));
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic step();
    bit          e_mv;
    bit          done_now;
    bit          e_rdy [2];
    bit          e_err [2];
    logic [31:0] e_rd [2];
    int          pick;
    @(negedge clock);
    for (int p = 0; p < 2; p++) begin
      if (r_done[p] || rst_drv) begin
        r_v[p] = 1'b0;
        r_done[p] = 1'b0;
      end
      if (!r_v[p] && !rst_drv && gen_pct > 0 && int'($urandom_range(0, 99)) < gen_pct)
        new_req(p);
    end
    imem_valid = r_v[0]; imem_instr = r_instr[0]; imem_addr = r_addr[0];
    imem_wdata = r_wdata[0]; imem_wstrb = r_wstrb[0];
    dmem_valid = r_v[1]; dmem_instr = r_instr[1]; dmem_addr = r_addr[1];
    dmem_wdata = r_wdata[1]; dmem_wstrb = r_wstrb[1];
    reset = rst_drv;
    mem_rdata = $urandom();
    if (force_ready) mem_ready = 1'b1;
    else if (m_active && m_mapped) mem_ready = (m_age - 1 >= m_lat);
    else mem_ready = noise_en && ($urandom_range(0, 1) == 1);
    #1;
    e_mv = m_active && m_mapped && !rst_drv;
    e_rdy = '{1'b0, 1'b0};
    e_err = '{1'b0, 1'b0};
    e_rd = '{32'h0, 32'h0};
    done_now = 1'b0;
    if (!rst_drv && m_active) begin
      if (m_mapped) begin
        if (mem_ready) begin
          e_rdy[m_port] = 1'b1;
          e_rd[m_port] = mem_rdata;
          done_now = 1'b1;
        end
      end else if (m_age == 2) begin
        e_rdy[m_port] = 1'b1;
        e_err[m_port] = 1'b1;
        done_now = 1'b1;
      end
    end
    check("mem_valid", 32'(mem_valid), 32'(e_mv));
    check("mem_instr", 32'(mem_instr), e_mv ? 32'(m_instr) : 32'h0);
    check("mem_addr", mem_addr, e_mv ? m_addr : 32'h0);
    check("mem_wdata", mem_wdata, e_mv ? m_wdata : 32'h0);
    check("mem_wstrb", 32'(mem_wstrb), e_mv ? 32'(m_wstrb) : 32'h0);
    check("imem_ready", 32'(imem_ready), 32'(e_rdy[0]));
    check("imem_error", 32'(imem_error), 32'(e_err[0]));
    check("imem_rdata", imem_rdata, e_rd[0]);
    check("dmem_ready", 32'(dmem_ready), 32'(e_rdy[1]));
    check("dmem_error", 32'(dmem_error), 32'(e_err[1]));
    check("dmem_rdata", dmem_rdata, e_rd[1]);
    if (imem_ready === 1'b1) obs_q.push_back(0);
    if (dmem_ready === 1'b1) obs_q.push_back(1);
    if (dmem_error === 1'b1) err_cnt++;
    if (mem_valid === 1'b1) begin
      mv_cnt++;
      seen_addr = mem_addr;
      seen_wdata = mem_wdata;
      seen_wstrb = mem_wstrb;
    end
    if (rst_drv) begin
      m_active = 1'b0;
      m_last = 0;
    end else if (m_active) begin
      if (done_now) begin
        m_active = 1'b0;
        r_done[m_port] = 1'b1;
      end else begin
        m_age++;
      end
    end else if (r_v[0] || r_v[1]) begin
      pick = (r_v[0] && r_v[1]) ? ((m_last == 0) ? 1 : 0) : (r_v[1] ? 1 : 0);
      m_active = 1'b1;
      m_port = pick;
      m_last = pick;
      m_age = 1;
      m_instr = r_instr[pick];
      m_addr = r_addr[pick];
      m_wdata = r_wdata[pick];
      m_wstrb = r_wstrb[pick];
      m_mapped = is_mapped(r_addr[pick]);
      m_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    end
  endtask

  task automatic drain();
    int n = 0;
    gen_pct = 0;
    while ((m_active || r_v[0] || r_v[1]) && n < 50) begin
      step();
      n++;
    end
    step();
  endtask

  task automatic set_req(input int p, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    r_v[p] = 1'b1; r_instr[p] = ins; r_addr[p] = a; r_wdata[p] = wd; r_wstrb[p] = ws;
  endtask

  initial begin
    int n;
    int base;
    repeat (3) step();
    rst_drv = 1'b0;
    repeat (2) step();

    // Single imem fetch at 0x10, slave answers 2 cycles after mem_valid.
    fixed_lat = 2;
    base = obs_q.size();
    set_req(0, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
    n = 0;
    while (obs_q.size() == base && n < 20) begin step(); n++; end
    check("i_latency", 32'(n), 32'd4);
    check("i_port", (obs_q.size() > base) ? 32'(obs_q[base]) : 32'd9, 32'd0);
    drain();

    // Both ports held valid from reset: dmem first, then strict alternation.
    fixed_lat = -1;
    rst_drv = 1'b1; step(); rst_drv = 1'b0;
    new_req(0); new_req(1);
    gen_pct = 100;
    base = obs_q.size();
    n = 0;
    while (obs_q.size() - base < 6 && n < 200) begin step(); n++; end
    for (int k = 0; k < 6; k++)
      check("alt_grant", (obs_q.size() > base + k) ? 32'(obs_q[base + k]) : 32'd9,
            (k % 2 == 0) ? 32'd1 : 32'd0);
    drain();

    // Unmapped dmem write: local error response, no bus traffic.
    mv_cnt = 0; err_cnt = 0; base = obs_q.size();
    set_req(1, 1'b0, 32'h0300_0000, 32'h1234_5678, 4'hF);
    repeat (5) step();
    check("err_len", 32'(err_cnt), 32'd1);
    check("err_no_bus", 32'(mv_cnt), 32'd0);
    check("err_resp", 32'(obs_q.size() - base), 32'd1);

    // Following mapped write carries exactly its fields on the bus.
    fixed_lat = 1; mv_cnt = 0; base = obs_q.size();
    set_req(1, 1'b0, 32'h0100_0000, 32'h0000_00A5, 4'h1);
    n = 0;
    while (obs_q.size() == base && n < 20) begin step(); n++; end
    check("wr_addr", seen_addr, 32'h0100_0000);
    check("wr_wdata", seen_wdata, 32'h0000_00A5);
    check("wr_wstrb", 32'(seen_wstrb), 32'h1);
    check("wr_cycles", 32'(mv_cnt), 32'd2);
    drain();

    // Reset in BUSY_D while the slave answers: no ready pulse.
    fixed_lat = 5; mv_cnt = 0;
    set_req(1, 1'b0, 32'h8000_0100, 32'h0, 4'h0);
    repeat (2) step();
    base = obs_q.size();
    rst_drv = 1'b1; force_ready = 1'b1;
    step();
    rst_drv = 1'b0; force_ready = 1'b0;
    step();
    check("rst_was_busy", 32'(mv_cnt), 32'd1);
    check("rst_no_ready", 32'(obs_q.size() - base), 32'd0);
    drain();

    // Randomized traffic with slave noise and occasional resets.
    fixed_lat = -1; noise_en = 1'b1; gen_pct = 40;
    for (int i = 0; i < 1500; i++) begin
      rst_drv = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_drv = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no parameters; it SHALL take its address map (rom, uart, clint, avl base/top) from package configure.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock, all state on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports imem_valid/imem_instr, input, 1 bit each: instruction-port request and its fetch flag.
REQ-005 The block SHALL have ports imem_addr/imem_wdata, input, 32 bits each, and imem_wstrb, input, 4 bits.
REQ-006 The block SHALL have ports imem_rdata, output, 32 bits, and imem_ready/imem_error, output, 1 bit each.
REQ-007 The block SHALL have data-port ports dmem_* with the same names, directions and widths as REQ-004..006.
REQ-008 The block SHALL have downstream outputs mem_valid/mem_instr (1 bit), mem_addr/mem_wdata (32 bits) and mem_wstrb (4 bits).
REQ-009 The block SHALL have downstream inputs mem_rdata (32 bits) and mem_ready (1 bit).

Function
REQ-010 The block SHALL implement an FSM with states IDLE, BUSY_I, BUSY_D and ERR.
REQ-011 Requesters SHALL hold valid and all request fields stable until their ready; the block SHALL NOT check this.
REQ-012 In IDLE with exactly one valid, that port SHALL be granted.
REQ-013 In IDLE with both valid, grant SHALL go to the port not served last; after reset dmem has priority.
REQ-014 On grant, addr/wdata/wstrb/instr SHALL be latched at the clock edge, and the last-served flag SHALL update.
REQ-015 A latched address is mapped when base <= addr < top for rom, uart, clint or avl (unsigned 32-bit compare); otherwise it is unmapped.
REQ-016 A mapped grant SHALL move the FSM to BUSY_I/BUSY_D, with mem_valid=1 and latched fields driven from the next cycle (1-cycle request latency).
REQ-017 In BUSY_x, mem_valid SHALL stay 1 and fields stable until a cycle where mem_ready=1.
REQ-018 In that cycle, x_ready=1 and x_rdata=mem_rdata combinationally, the other port's ready=0, and the FSM SHALL return to IDLE next cycle.
REQ-019 An unmapped grant SHALL go to ERR without asserting mem_valid.
REQ-020 ERR SHALL last one cycle with x_ready=1, x_error=1 and x_rdata=0, then return to IDLE.
REQ-021 The block SHALL keep at most one outstanding downstream transaction.
REQ-022 No new grant SHALL occur in a completion cycle, so back-to-back transfers are separated by one IDLE cycle.
REQ-023 mem_ready SHALL be ignored in IDLE and ERR.
REQ-024 A non-granted port's ready, error and rdata SHALL be 0.
REQ-025 When both ports are valid continuously, grants SHALL strictly alternate (no starvation).

Reset
REQ-026 While reset=1 at an edge, the FSM SHALL enter IDLE, last-served SHALL be set to imem, and latched fields SHALL clear to 0.
REQ-027 From the first cycle after reset is sampled, all outputs SHALL be 0 (mem_valid, mem_*, *_ready, *_error, *_rdata).
REQ-028 Reset during BUSY or ERR SHALL abandon the transaction with no ready pulse to any requester.

Structure
REQ-029 Package configure SHALL gain typedef mem_req_t (valid, instr, addr, wdata, wstrb), shared with the core and peripherals.
REQ-030 The FSM state enum SHALL be local to mem_arbiter.
REQ-031 Address decode SHALL live in combinational sub-module mem_decoder (input 32-bit addr, output 1-bit mapped), instantiated once on the latched address.

Verification
REQ-032 imem-only read 0x00000010, slave ready 2 cycles after mem_valid -> mem_valid rises 1 cycle after request; imem_ready pulses with rdata passed through; dmem_ready=0.
REQ-033 imem and dmem valid in the same cycle after reset -> dmem served first, then imem, with one IDLE cycle between.
REQ-034 Both ports held valid for 6 transfers -> grants alternate D,I,D,I,D,I.
REQ-035 dmem write to 0x03000000 (unmapped) -> mem_valid never asserted; dmem_ready=1, dmem_error=1, dmem_rdata=0 for exactly one cycle; next request proceeds normally.
REQ-036 dmem write addr 0x1000000, wdata 0xA5, wstrb 0x1 -> mem_* carry exactly these values while mem_valid=1.
REQ-037 Reset asserted in BUSY_D with slave ready arriving the same cycle -> no dmem_ready pulse; all outputs 0 the next cycle.
